// File: rtl/uart_int_bus_arbiter.sv
// Two-master round-robin grant arbiter sitting behind the UART2BUS request/grant handshake.
// Supports programmable grant latency, int decline mode, grant-hold timeout and saturating grant counters.
module uart_int_bus_arbiter #(
    parameter int DLY_W  = 4,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              int_req,
    output logic              int_gnt,
    input  logic              ext_req,
    output logic              ext_gnt,
    input  logic [DLY_W-1:0]  gnt_delay,
    input  logic [HOLD_W-1:0] max_hold,
    input  logic              deny_int,
    output logic              timeout,
    output logic [CNT_W-1:0]  int_gnt_cnt,
    output logic [CNT_W-1:0]  ext_gnt_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        GRANT_INT = 2'd2,
        GRANT_EXT = 2'd3
    } state_t;

    localparam logic [DLY_W-1:0]  DLY_ZERO  = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0]  DLY_ONE   = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_r, state_nxt_s;
    logic [DLY_W-1:0]  dly_cnt_r, dly_cnt_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              sel_ext_r, sel_ext_nxt_s;
    logic              last_ext_r, last_ext_nxt_s;
    logic              timeout_r, timeout_nxt_s;
    logic              int_gnt_r, ext_gnt_r;
    logic [CNT_W-1:0]  int_cnt_r, ext_cnt_r;
    logic              int_elig_s, pick_ext_s, sel_req_s, cur_req_s;
    logic              enter_int_s, enter_ext_s;

    // Request qualification and round-robin pick
    always_comb begin
        int_elig_s = int_req & ~deny_int;
        if (int_elig_s && ext_req) begin
            pick_ext_s = ~last_ext_r;
        end else begin
            pick_ext_s = ext_req;
        end
        sel_req_s = sel_ext_r ? ext_req : int_elig_s;
        cur_req_s = (state_r == GRANT_EXT) ? ext_req : int_req;
    end

    // Next-state and bookkeeping decode
    always_comb begin
        state_nxt_s    = state_r;
        dly_cnt_nxt_s  = dly_cnt_r;
        sel_ext_nxt_s  = sel_ext_r;
        last_ext_nxt_s = last_ext_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (int_elig_s || ext_req) begin
                    sel_ext_nxt_s = pick_ext_s;
                    if (gnt_delay == DLY_ZERO) begin
                        state_nxt_s = pick_ext_s ? GRANT_EXT : GRANT_INT;
                    end else begin
                        state_nxt_s   = WAIT;
                        dly_cnt_nxt_s = gnt_delay - DLY_ONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // A dropped request (or int becoming denied) abandons the pending grant
                if (!sel_req_s) begin
                    state_nxt_s = IDLE;
                end else if (dly_cnt_r == DLY_ZERO) begin
                    state_nxt_s = sel_ext_r ? GRANT_EXT : GRANT_INT;
                end else begin
                    dly_cnt_nxt_s = dly_cnt_r - DLY_ONE;
                end
            end
            GRANT_INT, GRANT_EXT: begin
                if (!cur_req_s) begin
                    state_nxt_s    = IDLE;
                    last_ext_nxt_s = (state_r == GRANT_EXT);
                end else if ((max_hold != HOLD_ZERO) && (hold_cnt_r == (max_hold - HOLD_ONE))) begin
                    state_nxt_s    = IDLE;
                    last_ext_nxt_s = (state_r == GRANT_EXT);
                    timeout_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        enter_int_s = (state_nxt_s == GRANT_INT) && (state_r != GRANT_INT);
        enter_ext_s = (state_nxt_s == GRANT_EXT) && (state_r != GRANT_EXT);
    end

    // State, arbitration memory and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            dly_cnt_r  <= DLY_ZERO;
            sel_ext_r  <= 1'b0;
            last_ext_r <= 1'b1;
            timeout_r  <= 1'b0;
            int_gnt_r  <= 1'b0;
            ext_gnt_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dly_cnt_r  <= dly_cnt_nxt_s;
            sel_ext_r  <= sel_ext_nxt_s;
            last_ext_r <= last_ext_nxt_s;
            timeout_r  <= timeout_nxt_s;
            int_gnt_r  <= (state_nxt_s == GRANT_INT);
            ext_gnt_r  <= (state_nxt_s == GRANT_EXT);
        end
    end

    // Hold counter: cleared on grant entry, counts cycles the owner keeps requesting
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_r <= HOLD_ZERO;
        end else if (enter_int_s || enter_ext_s) begin
            hold_cnt_r <= HOLD_ZERO;
        end else if (((state_r == GRANT_INT) || (state_r == GRANT_EXT)) && cur_req_s && (hold_cnt_r != HOLD_MAX)) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    // Saturating grant statistics, bumped once per grant entry
    always_ff @(posedge clock) begin
        if (reset) begin
            int_cnt_r <= CNT_ZERO;
            ext_cnt_r <= CNT_ZERO;
        end else begin
            if (enter_int_s && (int_cnt_r != CNT_MAX)) begin
                int_cnt_r <= int_cnt_r + CNT_ONE;
            end else begin
                int_cnt_r <= int_cnt_r;
            end
            if (enter_ext_s && (ext_cnt_r != CNT_MAX)) begin
                ext_cnt_r <= ext_cnt_r + CNT_ONE;
            end else begin
                ext_cnt_r <= ext_cnt_r;
            end
        end
    end

    assign int_gnt     = int_gnt_r;
    assign ext_gnt     = ext_gnt_r;
    assign timeout     = timeout_r;
    assign int_gnt_cnt = int_cnt_r;
    assign ext_gnt_cnt = ext_cnt_r;

endmodule
